// File: rtl/kronos_types_pkg.sv
// Shared Kronos pipeline types.
// Holds the IF->ID payload, the default boot address and the fetch FSM encoding.
package kronos_types;

    // Payload handed from fetch to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        INIT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/kronos_fetch_skid.sv
// Generic one-entry skid register.
// Holds a single word while the downstream slot is busy. Clear has priority over
// everything else. Load and unload are never asserted together by the fetch unit,
// but if they were, load wins and the entry stays valid.
module kronos_fetch_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rstz_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for the single entry.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (unload_i) begin
            vld_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rstz_i) begin
        if (!rstz_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/kronos_fetch_unit.sv
// Kronos instruction fetch stage.
// Owns the PC, issues word reads on the instruction bus and hands {pc, ir} to decode
// over a vld/rdy handshake. A branch redirect from writeback flushes everything in
// flight and restarts fetching at the (word-aligned) target.
// Build option KRONOS_FETCH_SKID_EN: adds a skid entry behind the output register so
// instr_req no longer depends combinationally on pipe_out_rdy.
module kronos_fetch_unit
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_gnt,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output pipeIFID_t   fetch,
    output logic        pipe_out_vld,
    input  logic        pipe_out_rdy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    pipeIFID_t    out_q, out_d;
    logic         vld_q, vld_d;

    logic         slot_free;
    logic         grant;
    pipeIFID_t    captured;
    logic         skid_vld;
    pipeIFID_t    skid_data;

    // Target low bits are discarded; fetch is always word aligned.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^branch_target[1:0];

    // The output register can take a new word when empty or being drained this cycle.
    assign slot_free = ~vld_q | pipe_out_rdy;
    assign grant     = instr_req & instr_gnt;
    assign captured  = '{pc: pc_q, ir: instr_data};

`ifdef KRONOS_FETCH_SKID_EN
    // Request only depends on local state, so rdy never reaches the instruction bus.
    assign instr_req = (state_q == FETCH) & ~skid_vld & ~branch;

    // A grant that cannot go to the stalled output parks in the skid entry; the entry
    // drains into the output on the next free slot.
    kronos_fetch_skid #(
        .WIDTH ($bits(pipeIFID_t))
    ) u_skid (
        .clk_i    (clk),
        .rstz_i   (rstz),
        .clr_i    (branch),
        .load_i   (grant & ~slot_free),
        .unload_i (slot_free & skid_vld),
        .data_i   (captured),
        .vld_o    (skid_vld),
        .data_o   (skid_data)
    );
`else
    // Only request when the single output register is free (or being freed) this cycle.
    assign instr_req = (state_q == FETCH) & slot_free & ~branch;
    assign skid_vld  = 1'b0;
    assign skid_data = '0;
`endif

    // FSM, PC and output-slot next-state; branch overrides every other event.
    always_comb begin
        state_d = FETCH;
        pc_d    = pc_q;
        out_d   = out_q;
        vld_d   = vld_q;
        if (branch) begin
            pc_d  = {branch_target[31:2], 2'b00};
            vld_d = 1'b0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (slot_free) begin
                if (skid_vld) begin
                    out_d = skid_data;
                    vld_d = 1'b1;
                end else if (grant) begin
                    out_d = captured;
                    vld_d = 1'b1;
                end else begin
                    vld_d = 1'b0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= INIT;
            pc_q    <= BOOT_ADDR;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign instr_addr   = pc_q;
    assign fetch        = out_q;
    assign pipe_out_vld = vld_q;

endmodule

// File: tb/tb_kronos_fetch_unit.sv
// Bench for kronos_fetch_unit: a negedge monitor keeps a reference PC and a queue of
// expected {pc, ir} words (pushed on each grant, popped on each transfer to decode),
// and predicts req/vld every cycle; directed steps cover the boundary cases.
module tb_kronos_fetch_unit;
    import kronos_types::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_gnt;
    logic        branch;
    logic [31:0] branch_target;
    pipeIFID_t   fetch;
    logic        pipe_out_vld;
    logic        pipe_out_rdy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kronos_fetch_unit #(.BOOT_ADDR(BOOT)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_data    (instr_data),
        .instr_gnt     (instr_gnt),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch         (fetch),
        .pipe_out_vld  (pipe_out_vld),
        .pipe_out_rdy  (pipe_out_rdy)
    );

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign instr_data = mem_word(instr_addr);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard.
    pipeIFID_t   sb_q[$];
    pipeIFID_t   exp_w;
    logic [31:0] model_pc;
    logic        model_fetch;
    logic        prev_stall;
    pipeIFID_t   prev_fetch;
    logic        exp_req;

    always @(negedge clk or negedge rstz) begin
        if (!rstz) begin
            sb_q.delete();
            model_pc    = BOOT;
            model_fetch = 1'b0;
            prev_stall  = 1'b0;
        end else if (!clk) begin
`ifdef KRONOS_FETCH_SKID_EN
            exp_req = model_fetch & ~branch & (sb_q.size() < 2);
`else
            exp_req = model_fetch & ~branch & ((sb_q.size() == 0) | pipe_out_rdy);
`endif
            chk("req", {63'd0, instr_req}, {63'd0, exp_req});
            chk("vld", {63'd0, pipe_out_vld}, {63'd0, sb_q.size() > 0});
            if (instr_req) chk("addr", {32'd0, instr_addr}, {32'd0, model_pc});
            if (prev_stall) chk("hold", fetch, prev_fetch);
            if (branch) begin
                sb_q.delete();
                model_pc   = {branch_target[31:2], 2'b00};
                prev_stall = 1'b0;
            end else begin
                if (pipe_out_vld && pipe_out_rdy) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", {63'd0, 1'b1}, 64'd0);
                    end else begin
                        exp_w = sb_q.pop_front();
                        chk("fetch", fetch, exp_w);
                    end
                end
                if (instr_req && instr_gnt) begin
                    sb_q.push_back('{pc: model_pc, ir: mem_word(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                prev_stall = pipe_out_vld & ~pipe_out_rdy;
                prev_fetch = fetch;
            end
            model_fetch = 1'b1;
        end
    end

    logic [31:0] held_addr;
    logic        found;

    initial begin
        rstz          = 1'b0;
        instr_gnt     = 1'b0;
        pipe_out_rdy  = 1'b0;
        branch        = 1'b0;
        branch_target = 32'd0;
        step(2);
        chk("rst_vld",   {63'd0, pipe_out_vld}, 64'd0);
        chk("rst_req",   {63'd0, instr_req}, 64'd0);
        chk("rst_fetch", fetch, 64'd0);
        chk("rst_addr",  {32'd0, instr_addr}, {32'd0, BOOT});

        // 1: streaming with gnt=1, rdy=1.
        instr_gnt    = 1'b1;
        pipe_out_rdy = 1'b1;
        rstz         = 1'b1;
        step(1);
        chk("t1_addr0", {32'd0, instr_addr}, {32'd0, BOOT});
        chk("t1_req0",  {63'd0, instr_req}, 64'd1);
        step(1);
        chk("t1_vld",   {63'd0, pipe_out_vld}, 64'd1);
        chk("t1_pc0",   {32'd0, fetch.pc}, {32'd0, BOOT});
        chk("t1_addr4", {32'd0, instr_addr}, 64'd4);

        // 2: stall decode for 3 cycles while fetch.pc = 0x10.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pipe_out_vld && fetch.pc == 32'h10) found = 1'b1;
            else step(1);
        end
        chk("t2_wait", {63'd0, found}, 64'd1);
        pipe_out_rdy = 1'b0;
        #1;
`ifdef KRONOS_FETCH_SKID_EN
        chk("t2_req_skid", {63'd0, instr_req}, 64'd1);
        step(1);
        chk("t2_req_full", {63'd0, instr_req}, 64'd0);
        step(2);
`else
        chk("t2_req_stall", {63'd0, instr_req}, 64'd0);
        step(3);
`endif
        chk("t2_hold_pc", {32'd0, fetch.pc}, 64'h10);
        pipe_out_rdy = 1'b1;
        step(4);

        // 3: branch with vld=1 and a pending request.
        chk("t3_pre_vld", {63'd0, pipe_out_vld}, 64'd1);
        branch        = 1'b1;
        branch_target = 32'h8000_0102;
        #1;
        chk("t3_req_low", {63'd0, instr_req}, 64'd0);
        step(1);
        branch = 1'b0;
        #1;
        chk("t3_vld_low", {63'd0, pipe_out_vld}, 64'd0);
        chk("t3_addr",    {32'd0, instr_addr}, 64'h8000_0100);
        step(4);

        // 4: PC wraps from 0xFFFF_FFFC to 0.
        branch        = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        step(1);
        branch = 1'b0;
        step(2);
        chk("t4_wrap", {32'd0, instr_addr}, 64'd0);
        step(2);

        // 5: grant withheld for 5 cycles.
        instr_gnt = 1'b0;
        held_addr = instr_addr;
        step(5);
        chk("t5_addr", {32'd0, instr_addr}, {32'd0, held_addr});
        chk("t5_vld",  {63'd0, pipe_out_vld}, 64'd0);
        chk("t5_req",  {63'd0, instr_req}, 64'd1);
        instr_gnt = 1'b1;
        step(3);

        // 6: asynchronous reset in the middle of a stall.
        pipe_out_rdy = 1'b0;
        step(3);
        chk("t6_pre_vld", {63'd0, pipe_out_vld}, 64'd1);
        #2;
        rstz = 1'b0;
        #1;
        chk("t6_vld",   {63'd0, pipe_out_vld}, 64'd0);
        chk("t6_req",   {63'd0, instr_req}, 64'd0);
        chk("t6_fetch", fetch, 64'd0);
        step(1);
        rstz         = 1'b1;
        pipe_out_rdy = 1'b1;
        step(1);
        chk("t6_boot", {32'd0, instr_addr}, {32'd0, BOOT});
        step(5);

        // 7: branch arriving in INIT still redirects.
        rstz = 1'b0;
        step(1);
        rstz          = 1'b1;
        branch        = 1'b1;
        branch_target = 32'h0000_0043;
        step(1);
        branch = 1'b0;
        #1;
        chk("t7_addr", {32'd0, instr_addr}, 64'h40);
        chk("t7_req",  {63'd0, instr_req}, 64'd1);
        step(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
